// File: rtl/sfft_pkg.sv
// Shared definitions for the SFFT controller and its bench: FSM state codes and the
// default stochastic stream-length exponent.
package sfft_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StClear = 3'd2,
    StRun   = 3'd3,
    StDone  = 3'd4
  } sfft_state_e;

  localparam int unsigned SfftBitwidthDefault = 8;

endpackage

// File: rtl/sfft_ctrl.sv
// Frame sequencer for the stochastic FFT array: LOAD twiddles, CLEAR, RUN 2**BITWIDTH cycles, DONE.
// Optional macro SFFT_CTRL_CONT_EN chains frames from DONE straight to CLEAR when iStart is held.
module sfft_ctrl
  import sfft_pkg::*;
#(
  parameter int unsigned BITWIDTH = SfftBitwidthDefault,
  parameter int unsigned LOADCYC  = 1,
  parameter int unsigned FCNTW    = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iAbort,
  output logic                oRstN,
  output logic                oLoadW,
  output logic                oClr,
  output logic                oEn,
  output logic                oBusy,
  output logic                oDone,
  output logic [BITWIDTH-1:0] oCycCnt,
  output logic [FCNTW-1:0]    oFrameCnt
);

  localparam logic [3:0] LoadLast = 4'(LOADCYC - 1);

  sfft_state_e state_q;
  logic [3:0]  load_cnt_q;
  logic        start_ok;

  // Abort always beats start.
  assign start_ok = iStart & ~iAbort;

  always_ff @(posedge iClk) begin
    oRstN <= ~iRst;
    if (iRst) begin
      state_q    <= StIdle;
      load_cnt_q <= '0;
      oLoadW     <= 1'b0;
      oClr       <= 1'b0;
      oEn        <= 1'b0;
      oDone      <= 1'b0;
      oBusy      <= 1'b0;
      oCycCnt    <= '0;
      oFrameCnt  <= '0;
    end else if (iAbort && (state_q != StIdle)) begin
      state_q <= StIdle;
      oLoadW  <= 1'b0;
      oClr    <= 1'b0;
      oEn     <= 1'b0;
      oDone   <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q    <= StLoad;
            load_cnt_q <= '0;
            oLoadW     <= 1'b1;
            oBusy      <= 1'b1;
          end
        end
        StLoad: begin
          if (load_cnt_q == LoadLast) begin
            state_q <= StClear;
            oLoadW  <= 1'b0;
            oClr    <= 1'b1;
          end else begin
            load_cnt_q <= load_cnt_q + 4'd1;
          end
        end
        StClear: begin
          state_q <= StRun;
          oClr    <= 1'b0;
          oEn     <= 1'b1;
          oCycCnt <= '0;
        end
        StRun: begin
          if (oCycCnt == '1) begin
            state_q   <= StDone;
            oEn       <= 1'b0;
            oDone     <= 1'b1;
            oFrameCnt <= oFrameCnt + 1'b1;
          end else begin
            oCycCnt <= oCycCnt + 1'b1;
          end
        end
        StDone: begin
          oDone <= 1'b0;
`ifdef SFFT_CTRL_CONT_EN
          // Twiddles are still loaded, so a continued frame only needs a clear.
          if (start_ok) begin
            state_q <= StClear;
            oClr    <= 1'b1;
          end else begin
            state_q <= StIdle;
            oBusy   <= 1'b0;
          end
`else
          state_q <= StIdle;
          oBusy   <= 1'b0;
`endif
        end
        default: begin
          state_q <= StIdle;
          oLoadW  <= 1'b0;
          oClr    <= 1'b0;
          oEn     <= 1'b0;
          oDone   <= 1'b0;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfft_ctrl.sv
// Scoreboard bench for sfft_ctrl (BITWIDTH=4, LOADCYC=2, FCNTW=2): a frame-level timing model
// fills per-cycle expectations and a done queue; a negedge monitor compares every cycle.
module tb_sfft_ctrl;

  localparam int BW     = 4;
  localparam int L      = 2;
  localparam int RUNLEN = 1 << BW;

  logic          iClk;
  logic          iRst;
  logic          iStart;
  logic          iAbort;
  logic          oRstN;
  logic          oLoadW;
  logic          oClr;
  logic          oEn;
  logic          oBusy;
  logic          oDone;
  logic [BW-1:0] oCycCnt;
  logic [1:0]    oFrameCnt;

  sfft_ctrl #(
    .BITWIDTH(BW),
    .LOADCYC (L),
    .FCNTW   (2)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iStart   (iStart),
    .iAbort   (iAbort),
    .oRstN    (oRstN),
    .oLoadW   (oLoadW),
    .oClr     (oClr),
    .oEn      (oEn),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oCycCnt  (oCycCnt),
    .oFrameCnt(oFrameCnt)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    int         cyc;
    logic [1:0] fc;
  } done_t;

  // Cycle k is what the outputs show between edge k-1 and edge k.
  bit [3:0]   exp_str[int];   // {done, en, clr, loadw}
  bit         exp_busy[int];
  int         exp_cc[int];
  int         exp_fc[int];
  done_t      done_q[$];

  int         n_chk = 0;
  int         n_err = 0;
  int         edge_n = 0;
  logic       rst_smp = 1'b1;
  bit         mon_on = 0;
  int         idle_edge = 0;
  int         last_done = 0;
  bit         prev_hold = 0;
  logic [1:0] fc_model = 2'd0;
  int         mk;
  bit [3:0]   exp4;
  done_t      got;

  always @(posedge iClk) begin
    edge_n  <= edge_n + 1;
    rst_smp <= iRst;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, edge_n + 1, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Frame whose CLEAR is visible in cycle c.
  task automatic mark_frame(input int c, input bit load);
    if (load) begin
      for (int i = 1; i <= L; i++) begin
        exp_str[c-i]  = 4'b0001;
        exp_busy[c-i] = 1'b1;
      end
    end
    exp_str[c]  = 4'b0010;
    exp_busy[c] = 1'b1;
    for (int j = 0; j < RUNLEN; j++) begin
      exp_str[c+1+j]  = 4'b0100;
      exp_busy[c+1+j] = 1'b1;
      exp_cc[c+1+j]   = j;
    end
    exp_str[c+RUNLEN+1]  = 4'b1000;
    exp_busy[c+RUNLEN+1] = 1'b1;
    fc_model = fc_model + 2'd1;
    done_q.push_back('{cyc: c + RUNLEN + 1, fc: fc_model});
  endtask

  // Frame killed at edge a: nothing of it is visible after cycle a and it never completes.
  task automatic truncate(input int a);
    for (int k = a + 1; k <= a + RUNLEN + L + 4; k++) begin
      exp_str.delete(k);
      exp_busy.delete(k);
      exp_cc.delete(k);
    end
    void'(done_q.pop_back());
    fc_model = fc_model - 2'd1;
  endtask

  // kill: 0 none, 1 abort, 2 reset; koff is the killing edge relative to the CLEAR cycle.
  task automatic run_frame(input bit hold, input bit noise, input int kill, input int koff);
    int c, s, d, a, e, n;
    bit cont;
    cont = 0;
`ifdef SFFT_CTRL_CONT_EN
    cont = prev_hold;
`endif
    if (cont) begin
      c = last_done + 1;
      s = c - 1;
    end else begin
      while (edge_n + 1 < idle_edge) step();
      s = edge_n + 1;
      c = s + L + 1;
    end
    mark_frame(c, !cont);
    d = c + RUNLEN + 1;
    a = (kill != 0) ? c + koff : -1;
    if (cont && kill != 0 && a < c) a = c;
    while (1) begin
      e = edge_n + 1;
      iStart = hold || (e == s) || (noise && e > s && e < d && $urandom_range(0, 1) == 1);
      iAbort = (kill == 1 && e == a) || (kill == 2 && e == a && $urandom_range(0, 1) == 1);
      iRst   = (kill == 2 && e == a);
      step();
      if (e == ((kill != 0) ? a : d)) break;
    end
    iAbort = 1'b0;
    if (kill == 1) begin
      iStart = 1'b0;
      truncate(a);
      idle_edge = a + 1;
      prev_hold = 0;
    end else if (kill == 2) begin
      iStart = 1'b0;
      truncate(a);
      done_q.delete();
      fc_model = 2'd0;
      exp_fc[a+1] = 0;
      exp_cc[a+1] = 0;
      n = $urandom_range(1, 3);
      repeat (n - 1) step();
      iRst = 1'b0;
      idle_edge = a + n;
      prev_hold = 0;
    end else begin
      iStart    = hold;
      idle_edge = d + 1;
      last_done = d;
      prev_hold = hold;
    end
  endtask

  task automatic idle_start_abort();
    while (edge_n + 1 < idle_edge) step();
    iStart = 1'b1;
    iAbort = 1'b1;
    step();
    iStart = 1'b0;
    iAbort = 1'b0;
    idle_edge = edge_n + 1;
  endtask

  always @(negedge iClk) begin
    if (mon_on) begin
      mk   = edge_n + 1;
      exp4 = exp_str.exists(mk) ? exp_str[mk] : 4'b0000;
      chk("strobes", {oDone, oEn, oClr, oLoadW}, exp4);
      chk("onehot", $onehot0({oDone, oEn, oClr, oLoadW}), 1);
      chk("busy", oBusy, exp_busy.exists(mk));
      chk("rstn", oRstN, !rst_smp);
      if (exp_cc.exists(mk)) chk("cyccnt", oCycCnt, exp_cc[mk]);
      if (exp_fc.exists(mk)) chk("framecnt_reset", oFrameCnt, exp_fc[mk]);
      if (oDone) begin
        chk("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          got = done_q.pop_front();
          chk("done_cycle", mk, got.cyc);
          chk("done_framecnt", oFrameCnt, got.fc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int op, koff;
    iRst   = 1'b1;
    iStart = 1'b0;
    iAbort = 1'b0;
    step();
    mon_on    = 1;
    exp_fc[2] = 0;
    exp_cc[2] = 0;
    step();
    step();
    iRst = 1'b0;
    idle_edge = 10;

    run_frame(0, 0, 0, 0);       // nominal frame sampled at edge 10
    run_frame(0, 1, 1, 6);       // abort at oCycCnt=5
    run_frame(1, 0, 0, 0);       // iStart held across three frames
    run_frame(1, 0, 0, 0);
    run_frame(0, 0, 0, 0);
    run_frame(0, 1, 2, 8);       // reset at oCycCnt=7
    idle_start_abort();
    for (int i = 0; i < 5; i++) run_frame(0, 1, 0, 0);  // frame counter wraps

    for (int i = 0; i < 25; i++) begin
      op   = $urandom_range(0, 5);
      koff = int'($urandom_range(0, L + RUNLEN)) - L;
      case (op)
        0, 1: run_frame(0, 1, 0, 0);
        2:    run_frame(0, 1, 1, koff);
        3:    run_frame(0, 1, 2, koff);
        4: begin
          run_frame(1, 0, 0, 0);
          run_frame(0, 0, 0, 0);
        end
        default: idle_start_abort();
      endcase
      repeat ($urandom_range(0, 3)) step();
    end

    while (edge_n + 1 < idle_edge) step();
    repeat (3) step();
    chk("drain_done_queue", done_q.size(), 0);
    chk("final_framecnt", oFrameCnt, fc_model);
    mon_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
